// File: rtl/dma_xfer_ctrl_if.sv
// Bus bundle for dma_xfer_ctrl: command, source read, destination write, buffer.
// The error pair exists only when DMA_XFER_CTRL_ERR_EN is defined.
interface dma_xfer_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_src_addr;
    logic [ADDR_WIDTH-1:0] i_dst_addr;
    logic [LEN_WIDTH-1:0]  i_len;
    logic                  o_busy;
    logic                  o_done;

    logic                  o_rd_req;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic                  i_rd_ready;
    logic                  i_rd_valid;
    logic [DATA_WIDTH-1:0] i_rd_data;

    logic                  o_wr_req;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [DATA_WIDTH-1:0] o_wr_data;
    logic                  i_wr_ready;

    logic                  o_buf_rd0_wr1;
    logic                  o_buf_valid;
    logic [DATA_WIDTH-1:0] o_buf_data;
    logic                  i_buf_valid;
    logic [DATA_WIDTH-1:0] i_buf_data;

`ifdef DMA_XFER_CTRL_ERR_EN
    logic                  i_bus_err;
    logic                  o_err;
`endif

    modport master (
        input  i_start, i_src_addr, i_dst_addr, i_len,
        input  i_rd_ready, i_rd_valid, i_rd_data,
        input  i_wr_ready,
        input  i_buf_valid, i_buf_data,
        output o_busy, o_done,
        output o_rd_req, o_rd_addr,
        output o_wr_req, o_wr_addr, o_wr_data,
        output o_buf_rd0_wr1, o_buf_valid, o_buf_data
`ifdef DMA_XFER_CTRL_ERR_EN
        , input i_bus_err
        , output o_err
`endif
    );

    modport slave (
        output i_start, i_src_addr, i_dst_addr, i_len,
        output i_rd_ready, i_rd_valid, i_rd_data,
        output i_wr_ready,
        output i_buf_valid, i_buf_data,
        input  o_busy, o_done,
        input  o_rd_req, o_rd_addr,
        input  o_wr_req, o_wr_addr, o_wr_data,
        input  o_buf_rd0_wr1, o_buf_valid, o_buf_data
`ifdef DMA_XFER_CTRL_ERR_EN
        , output i_bus_err
        , input o_err
`endif
    );
endinterface

// File: rtl/dma_xfer_ctrl.sv
// DMA transfer sequencer: bursts of up to DEPTH words through a staging buffer.
// Optional bus-error abort enabled by defining DMA_XFER_CTRL_ERR_EN.
module dma_xfer_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LEN_WIDTH  = 16
) (
    input logic             clk,
    input logic             rst,
    dma_xfer_ctrl_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] STEP =
        ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        BUF_WR,
        BUF_RD,
        BUF_WAIT,
        WR_REQ,
        DONE
    } state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] src_ptr, src_d;
    logic [ADDR_WIDTH-1:0] dst_ptr, dst_d;
    logic [LEN_WIDTH-1:0]  remaining, rem_d;
    logic [CW-1:0]         burst, burst_d;
    logic [CW-1:0]         fill, fill_d;
    logic [CW-1:0]         drain, drain_d;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] wr_data_d;
`ifdef DMA_XFER_CTRL_ERR_EN
    logic                  err_d;
`endif

    function automatic logic [CW-1:0] burst_len(
        input logic [LEN_WIDTH-1:0] n
    );
        return (n > LEN_WIDTH'(DEPTH)) ? CW'(DEPTH) : CW'(n);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            burst     <= '0;
            fill      <= '0;
            drain     <= '0;
        end else begin
            state     <= state_d;
            src_ptr   <= src_d;
            dst_ptr   <= dst_d;
            remaining <= rem_d;
            burst     <= burst_d;
            fill      <= fill_d;
            drain     <= drain_d;
        end
    end

    always_comb begin
        state_d   = state;
        src_d     = src_ptr;
        dst_d     = dst_ptr;
        rem_d     = remaining;
        burst_d   = burst;
        fill_d    = fill;
        drain_d   = drain;
        rd_data_d = bus.o_buf_data;
        wr_data_d = bus.o_wr_data;
`ifdef DMA_XFER_CTRL_ERR_EN
        err_d     = bus.o_err;
`endif
        unique case (state)
            IDLE: begin
                if (bus.i_start) begin
                    src_d   = bus.i_src_addr;
                    dst_d   = bus.i_dst_addr;
                    rem_d   = bus.i_len;
                    burst_d = burst_len(bus.i_len);
                    fill_d  = '0;
                    drain_d = '0;
`ifdef DMA_XFER_CTRL_ERR_EN
                    err_d   = 1'b0;
`endif
                    state_d = (bus.i_len == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                if (bus.i_rd_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
`ifdef DMA_XFER_CTRL_ERR_EN
                if (bus.i_bus_err) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else
`endif
                if (bus.i_rd_valid) begin
                    rd_data_d = bus.i_rd_data;
                    state_d   = BUF_WR;
                end
            end
            BUF_WR: begin
                fill_d  = fill + CW'(1);
                src_d   = src_ptr + STEP;
                state_d = (fill_d == burst) ? BUF_RD : RD_REQ;
            end
            BUF_RD: begin
                state_d = BUF_WAIT;
            end
            BUF_WAIT: begin
                if (bus.i_buf_valid) begin
                    wr_data_d = bus.i_buf_data;
                    state_d   = WR_REQ;
                end
            end
            WR_REQ: begin
`ifdef DMA_XFER_CTRL_ERR_EN
                if (bus.i_bus_err) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else
`endif
                if (bus.i_wr_ready) begin
                    dst_d   = dst_ptr + STEP;
                    drain_d = drain + CW'(1);
                    rem_d   = remaining - LEN_WIDTH'(1);
                    if (drain_d < burst) begin
                        state_d = BUF_RD;
                    end else if (rem_d == '0) begin
                        state_d = DONE;
                    end else begin
                        // next burst reuses the now-empty buffer
                        burst_d = burst_len(rem_d);
                        fill_d  = '0;
                        drain_d = '0;
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // outputs are registered from the next-state values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.o_busy        <= 1'b0;
            bus.o_done        <= 1'b0;
            bus.o_rd_req      <= 1'b0;
            bus.o_rd_addr     <= '0;
            bus.o_wr_req      <= 1'b0;
            bus.o_wr_addr     <= '0;
            bus.o_wr_data     <= '0;
            bus.o_buf_rd0_wr1 <= 1'b0;
            bus.o_buf_valid   <= 1'b0;
            bus.o_buf_data    <= '0;
`ifdef DMA_XFER_CTRL_ERR_EN
            bus.o_err         <= 1'b0;
`endif
        end else begin
            bus.o_busy        <= (state_d != IDLE) &&
                                 (state_d != DONE);
            bus.o_done        <= (state_d == DONE);
            bus.o_rd_req      <= (state_d == RD_REQ);
            bus.o_rd_addr     <= src_d;
            bus.o_wr_req      <= (state_d == WR_REQ);
            bus.o_wr_addr     <= dst_d;
            bus.o_wr_data     <= wr_data_d;
            bus.o_buf_rd0_wr1 <= (state_d == BUF_WR);
            bus.o_buf_valid   <= (state_d == BUF_WR) ||
                                 (state_d == BUF_RD);
            bus.o_buf_data    <= rd_data_d;
`ifdef DMA_XFER_CTRL_ERR_EN
            bus.o_err         <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Randomized bench for dma_xfer_ctrl with peer models and a transfer-level
// reference model; also covers DMA_XFER_CTRL_ERR_EN when it is defined.
module tb_dma_xfer_ctrl;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DEPTH = 16;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dma_xfer_ctrl_if #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) bus ();

    dma_xfer_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .DEPTH(DEPTH), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] q_rd[$];
    logic [31:0] q_bw[$];
    logic [31:0] q_wa[$];
    logic [31:0] q_wd[$];
    bit          q_op[$];
    logic [31:0] fifo[$];

    bit rd_act, rd_pend, wr_act, buf_ret, stall_en;
    bit exp_busy, exp_done, exp_err;
    int rd_stall, rd_dly, wr_stall, rd_served, err_at;
    int max_depth, writes_seen, dones, n_rd, n_bop;
    logic [31:0] rd_pend_addr, wr_hold_a, wr_hold_d;
    logic [31:0] first_ra, last_wa;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h",
                     name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s unexpected event", name);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // reference: word order, burst split and buffer op sequence
    task automatic model_cmd(input logic [31:0] src,
                             input logic [31:0] dst,
                             input int len);
        int rem, base, n;
        rem = len;
        base = 0;
        while (rem > 0) begin
            n = (rem > DEPTH) ? DEPTH : rem;
            for (int k = 0; k < n; k++) begin
                q_op.push_back(1'b1);
                q_rd.push_back(src + 32'(4 * (base + k)));
                q_bw.push_back(mem(src + 32'(4 * (base + k))));
            end
            for (int k = 0; k < n; k++) begin
                q_op.push_back(1'b0);
                q_wa.push_back(dst + 32'(4 * (base + k)));
                q_wd.push_back(mem(src + 32'(4 * (base + k))));
            end
            base += n;
            rem -= n;
        end
    endtask

    task automatic clear_model();
        q_rd.delete();
        q_bw.delete();
        q_wa.delete();
        q_wd.delete();
        q_op.delete();
        fifo.delete();
        rd_act = 0;
        rd_pend = 0;
        wr_act = 0;
        buf_ret = 0;
    endtask

    task automatic zero_inputs();
        bus.i_start = 0;
        bus.i_src_addr = '0;
        bus.i_dst_addr = '0;
        bus.i_len = '0;
        bus.i_rd_ready = 0;
        bus.i_rd_valid = 0;
        bus.i_rd_data = '0;
        bus.i_wr_ready = 0;
        bus.i_buf_valid = 0;
        bus.i_buf_data = '0;
`ifdef DMA_XFER_CTRL_ERR_EN
        bus.i_bus_err = 0;
`endif
    endtask

    // one negedge: compare outputs, then drive peer responses
    task automatic step();
        bit busy_n, done_n, err_n, pend0;
        logic [31:0] e;
        busy_n = exp_busy;
        done_n = 0;
        err_n = exp_err;
        pend0 = rd_pend;
        chk("busy", bus.o_busy, exp_busy);
        chk("done", bus.o_done, exp_done);
`ifdef DMA_XFER_CTRL_ERR_EN
        chk("err", bus.o_err, exp_err);
`endif
        if (bus.o_done) dones++;
        if (!exp_busy)
            chk("idle_quiet",
                {bus.o_rd_req, bus.o_wr_req, bus.o_buf_valid},
                3'b000);
        bus.i_start = 0;
        bus.i_rd_ready = 0;
        bus.i_rd_valid = 0;
        bus.i_wr_ready = 0;
        bus.i_buf_valid = 0;
`ifdef DMA_XFER_CTRL_ERR_EN
        bus.i_bus_err = 0;
`endif
        if (rd_pend) begin
            if (rd_dly > 0) rd_dly--;
`ifdef DMA_XFER_CTRL_ERR_EN
            else if (rd_served == err_at) begin
                bus.i_bus_err = 1;
                busy_n = 0;
                done_n = 1;
                err_n = 1;
                clear_model();
            end
`endif
            else begin
                bus.i_rd_valid = 1;
                bus.i_rd_data = mem(rd_pend_addr);
                rd_pend = 0;
                rd_served++;
            end
        end
        if (bus.o_rd_req) begin
            if (pend0) fail_now("rd_two_outstanding");
            if (!rd_act) begin
                rd_act = 1;
                rd_stall = stall_en ? int'($urandom_range(0, 5)) : 0;
            end
            if (rd_stall > 0) rd_stall--;
            else begin
                bus.i_rd_ready = 1;
                rd_act = 0;
                n_rd++;
                if (q_rd.size() == 0) fail_now("rd_extra");
                else begin
                    e = q_rd.pop_front();
                    chk("rd_addr", bus.o_rd_addr, e);
                end
                if (n_rd == 1) first_ra = bus.o_rd_addr;
                rd_pend = 1;
                rd_pend_addr = bus.o_rd_addr;
                rd_dly = stall_en ? int'($urandom_range(0, 5)) : 0;
            end
        end
        if (buf_ret) begin
            buf_ret = 0;
            if (fifo.size() == 0) fail_now("buf_underflow");
            else begin
                bus.i_buf_valid = 1;
                bus.i_buf_data = fifo.pop_front();
            end
        end
        if (bus.o_buf_valid) begin
            n_bop++;
            if (q_op.size() == 0) fail_now("buf_op_extra");
            else chk("buf_op", bus.o_buf_rd0_wr1, q_op.pop_front());
            if (bus.o_buf_rd0_wr1) begin
                if (q_bw.size() == 0) fail_now("buf_wdata_extra");
                else chk("buf_wdata", bus.o_buf_data, q_bw.pop_front());
                fifo.push_back(bus.o_buf_data);
                if (fifo.size() > max_depth) max_depth = fifo.size();
            end else begin
                buf_ret = 1;
            end
        end
        if (bus.o_wr_req) begin
            if (!wr_act) begin
                wr_act = 1;
                wr_stall = stall_en ? int'($urandom_range(0, 5)) : 0;
                wr_hold_a = bus.o_wr_addr;
                wr_hold_d = bus.o_wr_data;
            end else begin
                chk("wr_hold", {bus.o_wr_addr, bus.o_wr_data},
                    {wr_hold_a, wr_hold_d});
            end
            if (wr_stall > 0) wr_stall--;
            else begin
                bus.i_wr_ready = 1;
                wr_act = 0;
                writes_seen++;
                last_wa = bus.o_wr_addr;
                if (q_wa.size() == 0) fail_now("wr_extra");
                else begin
                    chk("wr_addr", bus.o_wr_addr, q_wa.pop_front());
                    chk("wr_data", bus.o_wr_data, q_wd.pop_front());
                    if (q_wa.size() == 0) begin
                        busy_n = 0;
                        done_n = 1;
                    end
                end
            end
        end
        exp_busy = busy_n;
        exp_done = done_n;
        exp_err = err_n;
    endtask

    task automatic start_cmd(input logic [31:0] src,
                             input logic [31:0] dst,
                             input int len);
        @(negedge clk);
        step();
        bus.i_start = 1;
        bus.i_src_addr = src;
        bus.i_dst_addr = dst;
        bus.i_len = 16'(len);
        model_cmd(src, dst, len);
        writes_seen = 0;
        n_rd = 0;
        n_bop = 0;
        max_depth = 0;
        rd_served = 0;
        if (len == 0) exp_done = 1;
        else exp_busy = 1;
        exp_err = 0;
    endtask

    task automatic run_cmd(input logic [31:0] src,
                           input logic [31:0] dst,
                           input int len,
                           input bit stalls,
                           input bit extra,
                           output int cyc);
        int d0;
        stall_en = stalls;
        start_cmd(src, dst, len);
        d0 = dones;
        cyc = 0;
        while (dones == d0 && cyc < 4000) begin
            @(negedge clk);
            step();
            cyc++;
            if (extra && exp_busy && $urandom_range(0, 3) == 0) begin
                bus.i_start = 1;
                bus.i_src_addr = $urandom();
                bus.i_dst_addr = $urandom();
                bus.i_len = 16'd3;
            end
        end
        if (dones == d0) fail_now("done_timeout");
        chk("queues_drained",
            q_rd.size() + q_wa.size() + q_op.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int len;
        logic [31:0] src, dst;
        zero_inputs();
        clear_model();
        exp_busy = 0;
        exp_done = 0;
        exp_err = 0;
        err_at = -1;
        dones = 0;
        stall_en = 0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl",
            {bus.o_busy, bus.o_done, bus.o_rd_req, bus.o_wr_req,
             bus.o_buf_valid, bus.o_buf_rd0_wr1}, 6'b0);
        chk("reset_data",
            {31'b0, |{bus.o_rd_addr, bus.o_wr_addr,
                      bus.o_wr_data, bus.o_buf_data}}, 0);
        rst = 1;

        run_cmd(32'h1000, 32'h2000, 4, 0, 0, cyc);
        chk("len4_latency", cyc, 25);
        chk("len4_first_rd", first_ra, 32'h1000);
        chk("len4_last_wr", last_wa, 32'h200C);
        chk("len4_writes", writes_seen, 4);

        run_cmd(32'h1000, 32'h2000, 20, 0, 0, cyc);
        chk("len20_latency", cyc, 121);
        chk("len20_writes", writes_seen, 20);
        chk("len20_last_wr", last_wa, 32'h204C);
        chk("len20_max_fill", max_depth, 16);

        run_cmd(32'h5000, 32'h6000, 0, 0, 0, cyc);
        chk("len0_latency", cyc, 1);
        chk("len0_activity", n_rd + n_bop + writes_seen, 0);

        run_cmd(32'hFFFF_FFF8, 32'hFFFF_FFF0, 6, 1, 0, cyc);
        chk("wrap_last_wr", last_wa, 32'h0000_0004);

        for (int i = 0; i < 6; i++) begin
            src = $urandom() & 32'hFFFF_FFFC;
            dst = $urandom() & 32'hFFFF_FFFC;
            len = int'($urandom_range(1, 40));
            run_cmd(src, dst, len, 1, 1, cyc);
            chk("rand_writes", writes_seen, len);
        end

        stall_en = 0;
        start_cmd(32'h3000, 32'h4000, 6);
        cyc = 0;
        while (cyc < 500) begin
            @(negedge clk);
            if (bus.o_wr_req && writes_seen == 2) break;
            step();
            cyc++;
        end
        if (cyc >= 500) fail_now("reach_word3_timeout");
        #2;
        zero_inputs();
        rst = 0;
        #1;
        chk("abort_ctrl",
            {bus.o_busy, bus.o_done, bus.o_rd_req, bus.o_wr_req,
             bus.o_buf_valid, bus.o_buf_rd0_wr1}, 6'b0);
        chk("abort_data",
            {31'b0, |{bus.o_rd_addr, bus.o_wr_addr,
                      bus.o_wr_data, bus.o_buf_data}}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", bus.o_done, 0);
        end
        clear_model();
        exp_busy = 0;
        exp_done = 0;
        rst = 1;
        run_cmd(32'h3100, 32'h4100, 2, 0, 0, cyc);
        chk("post_reset_writes", writes_seen, 2);
        chk("post_reset_last_wr", last_wa, 32'h4104);

`ifdef DMA_XFER_CTRL_ERR_EN
        err_at = 1;
        run_cmd(32'h7000, 32'h8000, 4, 0, 0, cyc);
        err_at = -1;
        chk("err_no_writes", writes_seen, 0);
        chk("err_set", bus.o_err, 1);
        run_cmd(32'h7100, 32'h8100, 2, 0, 0, cyc);
        chk("err_cleared", bus.o_err, 0);
        chk("err_next_writes", writes_seen, 2);
`endif

        repeat (4) begin
            @(negedge clk);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
